// File: rtl/wts_bridge_pkg.sv
// Shared types and helpers for the wave-table sound bus bridge.
// Holds the request FSM states, the latency counter width and the gain/saturate function.
package wts_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM,
    ST_CORE
  } state_e;

  localparam int CNT_W = 4;

  // Shifts a sign-extended sample left by gain and clamps it to an out_w-bit signed range.
  function automatic logic signed [63:0] sat_shift(input logic signed [31:0] sample,
                                                   input int gain,
                                                   input int out_w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = {{32{sample[31]}}, sample};
    s  = s <<< gain;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/wts_sample_scaler.sv
// Registered gain/saturate stage turning a signed core sample into a signed output sample.
// One-cycle latency; instantiated once per audio channel by wts_bus_bridge.
module wts_sample_scaler
  import wts_bridge_pkg::*;
#(
  parameter int CORE_W  = 11,
  parameter int OUT_W   = 15,
  parameter int GAIN_SH = 3
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [CORE_W-1:0] sample,
  output logic [OUT_W-1:0]  wav
);

  if (CORE_W < 1 || CORE_W > 31) begin : g_bad_core_w
    $error("wts_sample_scaler: CORE_W out of range");
  end
  if (GAIN_SH < 0 || GAIN_SH > OUT_W - 1) begin : g_bad_gain
    $error("wts_sample_scaler: GAIN_SH out of range");
  end
  if (CORE_W + GAIN_SH + 1 > 64) begin : g_bad_sum
    $error("wts_sample_scaler: CORE_W + GAIN_SH too wide");
  end

  logic [OUT_W-1:0] wav_d;
  logic [OUT_W-1:0] wav_q;

  always_comb begin
    wav_d = OUT_W'(sat_shift({{(32-CORE_W){sample[CORE_W-1]}}, sample}, GAIN_SH, OUT_W));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wav_q <= '0;
    end else begin
      wav_q <= wav_d;
    end
  end

  assign wav = wav_q;

endmodule

// File: rtl/wts_bus_bridge.sv
// Slot-bus bridge to the wave-table core and mapper RAM, plus the audio output stage.
// Define WTS_BUS_BRIDGE_STEREO_EN for an independent right channel; otherwise wavr mirrors wavl.
module wts_bus_bridge
  import wts_bridge_pkg::*;
#(
  parameter int RAM_ADR_W   = 21,
  parameter int RAM_LAT     = 1,
  parameter int CORE_RD_LAT = 10,
  parameter int CORE_W      = 11,
  parameter int OUT_W       = 15,
  parameter int GAIN_SH     = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req,
  input  logic                 wrt,
  input  logic [15:0]          adr,
  input  logic [7:0]           dbo,
  output logic                 ack,
  output logic [7:0]           dbi,
  output logic                 ramreq,
  output logic                 ramwrt,
  output logic [RAM_ADR_W-1:0] ramadr,
  input  logic [7:0]           ramdbi,
  output logic [7:0]           ramdbo,
  output logic                 core_wrreq,
  output logic                 core_rdreq,
  output logic                 core_wr_active,
  output logic                 core_rd_active,
  output logic [14:0]          core_a,
  output logic [7:0]           core_d,
  input  logic [7:0]           core_q,
  input  logic                 core_mem_ncs,
  input  logic [RAM_ADR_W-14:0] core_mem_a,
  input  logic [CORE_W-1:0]    core_left,
  input  logic [CORE_W-1:0]    core_right,
  output logic [OUT_W-1:0]     wavl,
  output logic [OUT_W-1:0]     wavr
);

  if (RAM_LAT < 1 || RAM_LAT > 15) begin : g_bad_ram_lat
    $error("wts_bus_bridge: RAM_LAT must be 1..15");
  end
  if (CORE_RD_LAT < 1 || CORE_RD_LAT > 15) begin : g_bad_core_lat
    $error("wts_bus_bridge: CORE_RD_LAT must be 1..15");
  end
  if (RAM_ADR_W < 14) begin : g_bad_adr_w
    $error("wts_bus_bridge: RAM_ADR_W must be at least 14");
  end

  localparam logic [CNT_W-1:0] RAM_CNT  = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0] CORE_CNT = CNT_W'(CORE_RD_LAT);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [14:0]      adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic             wrt_q, wrt_d;
  logic [7:0]       dbi_q, dbi_d;

  // The counter runs down to 1; that cycle is the ack cycle for whichever target is active.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    wrt_d      = wrt_q;
    dbi_d      = dbi_q;
    ack        = 1'b0;
    ramreq     = 1'b0;
    core_wrreq = 1'b0;
    core_rdreq = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d      = adr[14:0];
          dat_d      = dbo;
          wrt_d      = wrt;
          core_wrreq = wrt;
          core_rdreq = !wrt;
          if (!core_mem_ncs) begin
            state_d = ST_RAM;
            cnt_d   = RAM_CNT;
          end else begin
            state_d = ST_CORE;
            cnt_d   = wrt ? ONE_CNT : CORE_CNT;
          end
        end
      end
      ST_RAM: begin
        ramreq = (cnt_q == RAM_CNT);
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == ONE_CNT) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!wrt_q) begin
            dbi_d = ramdbi;
          end
        end
      end
      ST_CORE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ONE_CNT) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!wrt_q) begin
            dbi_d = core_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      wrt_q   <= 1'b0;
      dbi_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      wrt_q   <= wrt_d;
      dbi_q   <= dbi_d;
    end
  end

  // Live address in IDLE lets the mapper decode core_mem_ncs during the request cycle.
  assign core_a         = (state_q == ST_IDLE) ? adr[14:0] : adr_q;
  assign core_d         = dat_q;
  assign core_wr_active = (state_q == ST_CORE) && wrt_q;
  assign core_rd_active = (state_q == ST_CORE) && !wrt_q;
  assign ramwrt         = wrt_q;
  assign ramdbo         = dat_q;
  assign ramadr         = {core_mem_a, adr_q[12:0]};
  assign dbi            = dbi_q;

  wts_sample_scaler #(
    .CORE_W (CORE_W),
    .OUT_W  (OUT_W),
    .GAIN_SH(GAIN_SH)
  ) u_scale_left (
    .clk   (clk),
    .nreset(nreset),
    .sample(core_left),
    .wav   (wavl)
  );

`ifdef WTS_BUS_BRIDGE_STEREO_EN
  wts_sample_scaler #(
    .CORE_W (CORE_W),
    .OUT_W  (OUT_W),
    .GAIN_SH(GAIN_SH)
  ) u_scale_right (
    .clk   (clk),
    .nreset(nreset),
    .sample(core_right),
    .wav   (wavr)
  );

  logic unused_in;
  assign unused_in = adr[15];
`else
  assign wavr = wavl;

  logic unused_in;
  assign unused_in = ^{adr[15], core_right};
`endif

endmodule

// File: tb/tb_wts_bus_bridge.sv
// Scoreboard testbench for wts_bus_bridge: bus transactions and audio samples are pushed
// as expectations by the stimulus and checked by independent monitors.
module tb_wts_bus_bridge;

  localparam int RAM_ADR_W   = 21;
  localparam int RAM_LAT     = 1;
  localparam int CORE_RD_LAT = 10;
  localparam int CORE_W      = 11;
  localparam int OUT_W       = 15;
  localparam int GAIN_SH     = 3;
  localparam int GAIN_SH_SAT = 5;
  localparam int BANK_W      = RAM_ADR_W - 13;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic                 req, wrt;
  logic [15:0]          adr;
  logic [7:0]           dbo;
  logic                 ack;
  logic [7:0]           dbi;
  logic                 ramreq, ramwrt;
  logic [RAM_ADR_W-1:0] ramadr;
  logic [7:0]           ramdbi, ramdbo;
  logic                 core_wrreq, core_rdreq, core_wr_active, core_rd_active;
  logic [14:0]          core_a;
  logic [7:0]           core_d, core_q;
  logic                 core_mem_ncs;
  logic [BANK_W-1:0]    core_mem_a;
  logic [CORE_W-1:0]    core_left, core_right;
  logic [OUT_W-1:0]     wavl, wavr;

  logic                 s_ack, s_ramreq, s_ramwrt;
  logic [7:0]           s_dbi, s_ramdbo, s_core_d;
  logic [RAM_ADR_W-1:0] s_ramadr;
  logic                 s_wrreq, s_rdreq, s_wra, s_rda;
  logic [14:0]          s_core_a;
  logic [OUT_W-1:0]     s_wavl, s_wavr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         req_cyc;
    int         ack_cyc;
    bit         is_core;
    bit         wrt;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    int                   cyc;
    logic [RAM_ADR_W-1:0] adr;
  } ramreq_t;

  typedef struct {
    int l;
    int r;
    int lsat;
  } aud_t;

  txn_t       exp_q[$];
  ramreq_t    ram_q[$];
  aud_t       aud_q[$];
  logic [7:0] model_dbi = 8'h00;
  logic [7:0] dbi_expect;
  bit         dbi_pending = 1'b0;

  wts_bus_bridge #(
    .RAM_ADR_W(RAM_ADR_W), .RAM_LAT(RAM_LAT), .CORE_RD_LAT(CORE_RD_LAT),
    .CORE_W(CORE_W), .OUT_W(OUT_W), .GAIN_SH(GAIN_SH)
  ) dut (
    .clk(clk), .nreset(nreset), .req(req), .wrt(wrt), .adr(adr), .dbo(dbo),
    .ack(ack), .dbi(dbi), .ramreq(ramreq), .ramwrt(ramwrt), .ramadr(ramadr),
    .ramdbi(ramdbi), .ramdbo(ramdbo), .core_wrreq(core_wrreq), .core_rdreq(core_rdreq),
    .core_wr_active(core_wr_active), .core_rd_active(core_rd_active), .core_a(core_a),
    .core_d(core_d), .core_q(core_q), .core_mem_ncs(core_mem_ncs), .core_mem_a(core_mem_a),
    .core_left(core_left), .core_right(core_right), .wavl(wavl), .wavr(wavr)
  );

  // Second instance with a larger gain so the saturation limits are exercised.
  wts_bus_bridge #(
    .RAM_ADR_W(RAM_ADR_W), .RAM_LAT(RAM_LAT), .CORE_RD_LAT(CORE_RD_LAT),
    .CORE_W(CORE_W), .OUT_W(OUT_W), .GAIN_SH(GAIN_SH_SAT)
  ) dut_sat (
    .clk(clk), .nreset(nreset), .req(1'b0), .wrt(1'b0), .adr(16'h0000), .dbo(8'h00),
    .ack(s_ack), .dbi(s_dbi), .ramreq(s_ramreq), .ramwrt(s_ramwrt), .ramadr(s_ramadr),
    .ramdbi(8'h00), .ramdbo(s_ramdbo), .core_wrreq(s_wrreq), .core_rdreq(s_rdreq),
    .core_wr_active(s_wra), .core_rd_active(s_rda), .core_a(s_core_a),
    .core_d(s_core_d), .core_q(8'h00), .core_mem_ncs(1'b0), .core_mem_a('0),
    .core_left(core_left), .core_right(core_right), .wavl(s_wavl), .wavr(s_wavr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Ideal scaling: multiply by 2^sh, then clamp to the signed output range.
  function automatic int refScale(input int s, input int sh);
    int v;
    int mx;
    v  = s * (1 << sh);
    mx = (1 << (OUT_W - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  task automatic checkResetState();
    checkOutput("rst_ack", int'(ack), 0);
    checkOutput("rst_ramreq", int'(ramreq), 0);
    checkOutput("rst_ramwrt", int'(ramwrt), 0);
    checkOutput("rst_dbi", int'(dbi), 0);
    checkOutput("rst_ramdbo", int'(ramdbo), 0);
    checkOutput("rst_core_d", int'(core_d), 0);
    checkOutput("rst_wr_active", int'(core_wr_active), 0);
    checkOutput("rst_rd_active", int'(core_rd_active), 0);
    checkOutput("rst_wavl", int'(wavl), 0);
    checkOutput("rst_wavr", int'(wavr), 0);
  endtask

  // Issues one request at the current negedge; returns at the negedge after the expected ack.
  // intrude > 0 drives an illegal request that many cycles after the accept.
  task automatic applyStimulus(input bit w, input bit is_core, input logic [15:0] a,
                               input logic [7:0] d, input logic [7:0] rdata,
                               input logic [BANK_W-1:0] bank, input int intrude);
    int      lat;
    txn_t    t;
    ramreq_t rr;
    lat = !is_core ? RAM_LAT : (w ? 1 : CORE_RD_LAT);
    req = 1'b1; wrt = w; adr = a; dbo = d;
    core_mem_ncs = is_core; core_mem_a = bank; ramdbi = rdata; core_q = rdata;
    t.req_cyc = cyc; t.ack_cyc = cyc + lat; t.is_core = is_core; t.wrt = w; t.data = rdata;
    exp_q.push_back(t);
    if (!is_core) begin
      rr.cyc = cyc + 1;
      rr.adr = {bank, a[12:0]};
      ram_q.push_back(rr);
    end
    #1;
    checkOutput("req_wrreq", int'(core_wrreq), int'(w));
    checkOutput("req_rdreq", int'(core_rdreq), int'(!w));
    checkOutput("req_core_a", int'(core_a), int'(a[14:0]));
    @(negedge clk);
    req = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (i == intrude) begin
        req = 1'b1; wrt = !w; adr = a ^ 16'h2A5A; dbo = ~d;
        #1;
        checkOutput("ign_wrreq", int'(core_wrreq), 0);
        checkOutput("ign_rdreq", int'(core_rdreq), 0);
        checkOutput("ign_core_a", int'(core_a), int'(a[14:0]));
      end
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic driveSample(input logic [CORE_W-1:0] l, input logic [CORE_W-1:0] r);
    aud_t e;
    core_left  = l;
    core_right = r;
    e.l    = refScale(int'($signed(l)), GAIN_SH);
    e.lsat = refScale(int'($signed(l)), GAIN_SH_SAT);
`ifdef WTS_BUS_BRIDGE_STEREO_EN
    e.r = refScale(int'($signed(r)), GAIN_SH);
`else
    e.r = e.l;
`endif
    aud_q.push_back(e);
    @(negedge clk);
  endtask

  // Bus monitor: ack timing, active flags, RAM request pulses and held read data.
  always @(negedge clk) begin
    #1;
    if (nreset) begin
      bit exp_ack, exp_wa, exp_ra, exp_rr;
      exp_ack = 1'b0; exp_wa = 1'b0; exp_ra = 1'b0; exp_rr = 1'b0;
      if (dbi_pending) begin
        checkOutput("dbi", int'(dbi), int'(dbi_expect));
        dbi_pending = 1'b0;
      end
      if (exp_q.size() > 0) begin
        exp_ack = (exp_q[0].ack_cyc == cyc);
        if (exp_q[0].is_core && cyc > exp_q[0].req_cyc && cyc <= exp_q[0].ack_cyc) begin
          exp_wa = exp_q[0].wrt;
          exp_ra = !exp_q[0].wrt;
        end
      end
      if (ram_q.size() > 0) exp_rr = (ram_q[0].cyc == cyc);
      checkOutput("ack", int'(ack), int'(exp_ack));
      checkOutput("wr_active", int'(core_wr_active), int'(exp_wa));
      checkOutput("rd_active", int'(core_rd_active), int'(exp_ra));
      checkOutput("ramreq", int'(ramreq), int'(exp_rr));
      if (exp_rr) begin
        checkOutput("ramadr", int'(ramadr), int'(ram_q[0].adr));
        void'(ram_q.pop_front());
      end
      if (exp_ack) begin
        txn_t t;
        t = exp_q.pop_front();
        dbi_expect  = t.wrt ? model_dbi : t.data;
        model_dbi   = dbi_expect;
        dbi_pending = 1'b1;
      end
    end
  end

  // Audio monitor: each sample driven before an edge appears on the outputs after it.
  always @(posedge clk) begin
    #2;
    if (aud_q.size() > 0) begin
      aud_t e;
      e = aud_q.pop_front();
      checkOutput("wavl", int'($signed(wavl)), e.l);
      checkOutput("wavr", int'($signed(wavr)), e.r);
      checkOutput("wavl_sat", int'($signed(s_wavl)), e.lsat);
    end
  end

  initial begin
    nreset = 1'b0; req = 1'b0; wrt = 1'b0; adr = '0; dbo = '0;
    ramdbi = '0; core_q = '0; core_mem_ncs = 1'b0; core_mem_a = '0;
    core_left = '0; core_right = '0;
    repeat (2) @(negedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    $display("[TB] directed bus transactions");
    applyStimulus(1'b0, 1'b0, 16'h5A12, 8'h00, 8'hC3, BANK_W'(8'h3F), 0);
    applyStimulus(1'b1, 1'b1, 16'h9800, 8'h55, 8'h00, '0, 0);
    applyStimulus(1'b0, 1'b1, 16'h9800, 8'h00, 8'h55, '0, 0);
    applyStimulus(1'b0, 1'b1, 16'h9800, 8'h00, 8'hA7, '0, 3);
    applyStimulus(1'b1, 1'b0, 16'h1234, 8'h9E, 8'h11, BANK_W'(8'h05), 0);

    $display("[TB] random bus transactions");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                    8'($urandom), 8'($urandom), BANK_W'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] reset during core read");
    begin
      txn_t t;
      req = 1'b1; wrt = 1'b0; adr = 16'h9800; core_mem_ncs = 1'b1; core_q = 8'h99;
      t.req_cyc = cyc; t.ack_cyc = cyc + CORE_RD_LAT; t.is_core = 1'b1; t.wrt = 1'b0;
      t.data = 8'h99;
      exp_q.push_back(t);
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
      nreset = 1'b0;
      exp_q.delete();
      ram_q.delete();
      model_dbi   = 8'h00;
      dbi_pending = 1'b0;
      #1;
      checkResetState();
      repeat (4) @(negedge clk);
      checkOutput("abort_no_ack", int'(ack), 0);
      nreset = 1'b1;
      repeat (CORE_RD_LAT + 2) @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 16'h9800, 8'h00, 8'h3C, '0, 0);

    $display("[TB] audio path");
    driveSample(CORE_W'(11'h3FF), CORE_W'(11'h000));
    driveSample(CORE_W'(11'h400), CORE_W'(11'h3FF));
    driveSample(CORE_W'(11'h100), CORE_W'(11'h700));
    driveSample(CORE_W'(11'h000), CORE_W'(11'h400));
    for (int n = 0; n < 60; n++) begin
      driveSample(CORE_W'($urandom), CORE_W'($urandom));
    end
    repeat (3) @(negedge clk);

    repeat (CORE_RD_LAT + 4) @(negedge clk);
    checkOutput("drain_bus", exp_q.size(), 0);
    checkOutput("drain_ram", ram_q.size(), 0);
    checkOutput("drain_audio", aud_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
